hazard_control_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It is the stall/flush counterpart to the forwarding unit. Forwarding resolves EX-stage operand hazards by bypassing. This block handles the hazards forwarding cannot resolve: load-use dependencies, taken-branch wrong-path instructions, and data-memory wait states. It drives hold, bubble and flush controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/hazard_control_unit.sv | 159 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze controller for the 5-stage pipeline: load-use stalls, taken-branch flushes, data-memory waits.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise the counter ports read 0.
module hazard_control_unit #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs1,
    input  logic             IF_ID_uses_rs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_MemAccess,
    input  logic             dmem_ready,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_EX_stall,
    output logic             EX_MEM_stall,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_LU_STALL = 1'b1;

    localparam logic [1:0]        LU_RELOAD = 2'(LU_STALL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    logic [0:0]        r_state;
    logic [1:0]        r_luCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_memTimeout;

    logic [0:0]        w_nextState;
    logic [1:0]        w_nextLuCnt;
    logic [WAIT_W-1:0] w_waitNext;
    logic              w_memWait;
    logic              w_loadUse;

    assign w_memWait = EX_MEM_MemAccess & ~dmem_ready;
    assign w_loadUse = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                       ((IF_ID_uses_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                        (IF_ID_uses_rs2 & (IF_ID_rs2 == ID_EX_rd)));

    // Freeze beats everything; a pending load-use stall ignores branches because EX holds a bubble.
    always_comb begin
        PC_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        ID_EX_stall   = 1'b0;
        EX_MEM_stall  = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        MEM_WB_bubble = 1'b0;
        w_nextState   = r_state;
        w_nextLuCnt   = r_luCnt;
        if (rst) begin
            w_nextState = ST_RUN;
            w_nextLuCnt = 2'd0;
        end else if (w_memWait) begin
            PC_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            ID_EX_stall   = 1'b1;
            EX_MEM_stall  = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else if (r_state == ST_LU_STALL) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
            w_nextLuCnt = r_luCnt - 2'd1;
            if (r_luCnt == 2'd1) begin
                w_nextState = ST_RUN;
            end
        end else if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (w_loadUse) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                w_nextState = ST_LU_STALL;
                w_nextLuCnt = LU_RELOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_luCnt <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_luCnt <= w_nextLuCnt;
        end
    end

    assign w_waitNext = (r_waitCnt == WAIT_MAX) ? r_waitCnt : r_waitCnt + WAIT_W'(1);

    // The sticky flag sets on the same edge the wait counter reaches its limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else if (w_memWait) begin
            r_waitCnt <= w_waitNext;
            if (w_waitNext == WAIT_MAX) begin
                r_memTimeout <= 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

    assign mem_timeout = r_memTimeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushEvents;
    logic [CNT_W-1:0] r_memWaitCycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles   <= '0;
            r_flushEvents   <= '0;
            r_memWaitCycles <= '0;
        end else begin
            if (PC_stall) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if (IF_ID_flush) begin
                r_flushEvents <= r_flushEvents + CNT_W'(1);
            end
            if (w_memWait) begin
                r_memWaitCycles <= r_memWaitCycles + CNT_W'(1);
            end
        end
    end

    assign stall_cycles    = r_stallCycles;
    assign flush_events    = r_flushEvents;
    assign mem_wait_cycles = r_memWaitCycles;
`else
    assign stall_cycles    = '0;
    assign flush_events    = '0;
    assign mem_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1-cycle and 3-cycle load-use stall) checked every cycle
// against a debt-based reference model, plus hand-computed literal expectations for each scenario.
module tb_hazard_control_unit;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       memRead;
        logic [4:0] rd;
        logic       br;
        logic       acc;
        logic       rdy;
    } stim_t;

    localparam int TIMEOUT_T = 8;

    logic  clk = 1'b0;
    stim_t cur;
    int    checks = 0;
    int    errors = 0;
    bit    compareEn = 1'b0;

    always #5 clk = ~clk;

    logic        d1PcSt, d1IfSt, d1IdSt, d1ExSt, d1IfFl, d1IdFl, d1Bub, d1To;
    logic        d3PcSt, d3IfSt, d3IdSt, d3ExSt, d3IfFl, d3IdFl, d3Bub, d3To;
    logic [31:0] d1Stall, d1Flush, d1Wait, d3Stall, d3Flush, d3Wait;

    hazard_control_unit #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(TIMEOUT_T), .CNT_W(32)) dut1 (
        .clk(clk), .rst(cur.rst),
        .IF_ID_rs1(cur.rs1), .IF_ID_rs2(cur.rs2),
        .IF_ID_uses_rs1(cur.u1), .IF_ID_uses_rs2(cur.u2),
        .ID_EX_MemRead(cur.memRead), .ID_EX_rd(cur.rd),
        .EX_branch_taken(cur.br), .EX_MEM_MemAccess(cur.acc), .dmem_ready(cur.rdy),
        .PC_stall(d1PcSt), .IF_ID_stall(d1IfSt), .ID_EX_stall(d1IdSt), .EX_MEM_stall(d1ExSt),
        .IF_ID_flush(d1IfFl), .ID_EX_flush(d1IdFl), .MEM_WB_bubble(d1Bub),
        .mem_timeout(d1To), .stall_cycles(d1Stall), .flush_events(d1Flush), .mem_wait_cycles(d1Wait)
    );

    hazard_control_unit #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(TIMEOUT_T), .CNT_W(32)) dut3 (
        .clk(clk), .rst(cur.rst),
        .IF_ID_rs1(cur.rs1), .IF_ID_rs2(cur.rs2),
        .IF_ID_uses_rs1(cur.u1), .IF_ID_uses_rs2(cur.u2),
        .ID_EX_MemRead(cur.memRead), .ID_EX_rd(cur.rd),
        .EX_branch_taken(cur.br), .EX_MEM_MemAccess(cur.acc), .dmem_ready(cur.rdy),
        .PC_stall(d3PcSt), .IF_ID_stall(d3IfSt), .ID_EX_stall(d3IdSt), .EX_MEM_stall(d3ExSt),
        .IF_ID_flush(d3IfFl), .ID_EX_flush(d3IdFl), .MEM_WB_bubble(d3Bub),
        .mem_timeout(d3To), .stall_cycles(d3Stall), .flush_events(d3Flush), .mem_wait_cycles(d3Wait)
    );

    // Reference model: "owed" is how many more non-frozen stall cycles a load-use still demands.
    int          owed[2];
    int          waitRun[2];
    logic        toFlag[2];
    logic [31:0] cntStall[2];
    logic [31:0] cntFlush[2];
    logic [31:0] cntWait[2];

    function automatic int stallLen(int idx);
        return (idx == 0) ? 1 : 3;
    endfunction

    function automatic logic isLoadUse(stim_t s);
        return s.memRead && (s.rd != 5'd0) &&
               ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
    endfunction

    // Bits: PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, MEM_WB_bubble.
    function automatic logic [6:0] expOut(int owedV, stim_t s);
        if (s.rst) return 7'b000_0000;
        if (s.acc && !s.rdy) return 7'b111_1001;
        if (owedV > 0) return 7'b110_0010;
        if (s.br) return 7'b000_0110;
        if (isLoadUse(s)) return 7'b110_0010;
        return 7'b000_0000;
    endfunction

    function automatic logic [31:0] expCnt(logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            owed[i] = 0; waitRun[i] = 0; toFlag[i] = 1'b0;
            cntStall[i] = '0; cntFlush[i] = '0; cntWait[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [6:0] e;
            e = expOut(owed[i], cur);
            if (cur.rst) begin
                owed[i] = 0; waitRun[i] = 0; toFlag[i] = 1'b0;
                cntStall[i] = '0; cntFlush[i] = '0; cntWait[i] = '0;
            end else begin
                if (e[6]) cntStall[i] = cntStall[i] + 32'd1;
                if (e[2]) cntFlush[i] = cntFlush[i] + 32'd1;
                if (cur.acc && !cur.rdy) begin
                    cntWait[i] = cntWait[i] + 32'd1;
                    waitRun[i] = (waitRun[i] + 1 > TIMEOUT_T) ? TIMEOUT_T : waitRun[i] + 1;
                    if (waitRun[i] >= TIMEOUT_T) toFlag[i] = 1'b1;
                end else begin
                    waitRun[i] = 0;
                    if (owed[i] > 0) owed[i] = owed[i] - 1;
                    else if (!cur.br && isLoadUse(cur)) owed[i] = stallLen(i) - 1;
                end
            end
        end
        compareEn <= 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("d1 outputs", 64'({d1PcSt, d1IfSt, d1IdSt, d1ExSt, d1IfFl, d1IdFl, d1Bub}),
                        64'(expOut(owed[0], cur)));
            checkOutput("d3 outputs", 64'({d3PcSt, d3IfSt, d3IdSt, d3ExSt, d3IfFl, d3IdFl, d3Bub}),
                        64'(expOut(owed[1], cur)));
            checkOutput("d1 mem_timeout", 64'(d1To), 64'(toFlag[0]));
            checkOutput("d3 mem_timeout", 64'(d3To), 64'(toFlag[1]));
            checkOutput("d1 counters", {d1Stall, d1Flush}, {expCnt(cntStall[0]), expCnt(cntFlush[0])});
            checkOutput("d3 counters", {d3Stall, d3Flush}, {expCnt(cntStall[1]), expCnt(cntFlush[1])});
            checkOutput("d1 mem_wait_cycles", 64'(d1Wait), 64'(expCnt(cntWait[0])));
            checkOutput("d3 mem_wait_cycles", 64'(d3Wait), 64'(expCnt(cntWait[1])));
        end
    end

    int tally1;
    int tally3;

    // Drives one cycle of inputs just after the edge and returns at the following falling edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        cur = s;
        @(negedge clk);
        if (d1PcSt) tally1++;
        if (d3PcSt) tally3++;
    endtask

    function automatic stim_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                 logic memRead, logic [4:0] rd, logic br, logic acc, logic rdy);
        stim_t s;
        s.rst = rst; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
        s.memRead = memRead; s.rd = rd; s.br = br; s.acc = acc; s.rdy = rdy;
        return s;
    endfunction

    stim_t idle, luStim, memWaitStim, rstIdle;

    initial begin
        idle        = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
        luStim      = mk(0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 1);
        memWaitStim = mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        rstIdle     = idle;
        rstIdle.rst = 1'b1;
        cur = rstIdle;

        // Reset, with a load-use present while rst is high: nothing may assert.
        applyStimulus(rstIdle);
        begin
            stim_t s;
            s = luStim;
            s.rst = 1'b1;
            applyStimulus(s);
        end
        checkOutput("stall during reset", 64'({d1PcSt, d3PcSt, d3IdFl}), 64'd0);

        // Load-use: 1 cycle on dut1, 3 cycles on dut3.
        tally1 = 0; tally3 = 0;
        applyStimulus(luStim);
        checkOutput("lu1 first cycle", 64'({d1PcSt, d1IfSt, d1IdFl, d1IfFl}), 64'b1110);
        for (int i = 0; i < 4; i++) applyStimulus(idle);
        checkOutput("lu1 stall count", 64'(tally1), 64'd1);
        checkOutput("lu3 stall count", 64'(tally3), 64'd3);

        // Destination x0 never creates a load-use.
        tally1 = 0; tally3 = 0;
        applyStimulus(mk(0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 1));
        for (int i = 0; i < 2; i++) applyStimulus(idle);
        checkOutput("rd0 no stall", 64'(tally1 + tally3), 64'd0);

        // rs2 path, then unused-rs2 case.
        tally1 = 0;
        applyStimulus(mk(0, 5'd7, 5'd7, 0, 1, 1, 5'd7, 0, 0, 1));
        checkOutput("rs2 load-use", 64'(d1PcSt), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(idle);
        applyStimulus(mk(0, 5'd7, 5'd7, 0, 0, 1, 5'd7, 0, 0, 1));
        checkOutput("unused source", 64'(d1PcSt), 64'd0);
        applyStimulus(idle);

        // Two frozen cycles inside the stall window extend it without consuming the count.
        tally1 = 0; tally3 = 0;
        applyStimulus(luStim);
        applyStimulus(memWaitStim);
        applyStimulus(memWaitStim);
        for (int i = 0; i < 5; i++) applyStimulus(idle);
        checkOutput("lu3 with freeze", 64'(tally3), 64'd5);
        checkOutput("lu1 with freeze", 64'(tally1), 64'd3);

        // Taken branch wins over a simultaneous load-use and leaves the block in RUN.
        begin
            stim_t s;
            s = luStim;
            s.br = 1'b1;
            applyStimulus(s);
        end
        checkOutput("branch flush", 64'({d3IfFl, d3IdFl, d3PcSt, d3IfSt}), 64'b1100);
        applyStimulus(idle);
        checkOutput("run after branch", 64'({d3PcSt, d3IdFl}), 64'd0);

        // Four wait cycles freeze; the ready cycle releases.
        applyStimulus(rstIdle);
        tally1 = 0;
        for (int i = 0; i < 4; i++) applyStimulus(memWaitStim);
        checkOutput("freeze cycles", 64'(tally1), 64'd4);
        checkOutput("freeze pattern", 64'({d1ExSt, d1IdSt, d1Bub, d1IdFl}), 64'b1110);
        applyStimulus(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1));
        checkOutput("ready releases", 64'({d1PcSt, d1Bub, d1ExSt}), 64'd0);
        applyStimulus(idle);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("mem_wait_cycles", 64'(d1Wait), 64'd4);
`else
        checkOutput("mem_wait_cycles tied", 64'(d1Wait), 64'd0);
`endif

        // Timeout sets on the edge ending the 8th wait cycle and is sticky until reset.
        applyStimulus(rstIdle);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(memWaitStim);
            if (i == 8) checkOutput("timeout before 8th edge", 64'(d1To), 64'd0);
            if (i == 9) checkOutput("timeout after 8th edge", 64'(d1To), 64'd1);
        end
        applyStimulus(idle);
        checkOutput("timeout sticky", 64'({d1To, d3To}), 64'b11);
        applyStimulus(rstIdle);
        applyStimulus(idle);
        checkOutput("timeout cleared", 64'({d1To, d3To}), 64'd0);

        // Reset while dut3 sits in LU_STALL with two cycles still owed.
        applyStimulus(luStim);
        applyStimulus(rstIdle);
        checkOutput("reset mid-stall outputs", 64'({d3PcSt, d3IfSt, d3IdFl}), 64'd0);
        applyStimulus(idle);
        checkOutput("after reset mid-stall", 64'({d3PcSt, d3IdFl}), 64'd0);
        checkOutput("counters after reset", 64'(d3Stall), 64'd0);

        applyStimulus(idle);
        applyStimulus(idle);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
